// File: rtl/mux_rr_n_if.sv
// Handshake bundle for mux_rr_n: N producer channels in, one registered stream out.
// man_mode/sel exist only when MUX_MANUAL_SEL_EN is defined.
interface mux_rr_n_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;
`ifdef MUX_MANUAL_SEL_EN
  logic           man_mode;
  logic [SW-1:0]  sel;
`endif

  // slave: the mux itself; master: producers plus consumer
  modport slave (
    input  in_data, in_valid, out_ready,
`ifdef MUX_MANUAL_SEL_EN
    input  man_mode, sel,
`endif
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
`ifdef MUX_MANUAL_SEL_EN
    output man_mode, sel,
`endif
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_rr_n.sv
// N-channel registered round-robin mux with valid/ready on every channel and the output.
// Optional MUX_MANUAL_SEL_EN adds man_mode/sel for a forced channel choice.
module mux_rr_n_lane #(
  parameter int SW = 2,
  parameter int C  = 0
) (
  input  logic          gate,
  input  logic [SW-1:0] g,
  output logic          rdy
);
  assign rdy = gate && (g == SW'(C));
endmodule

module mux_rr_n #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      rst,
  mux_rr_n_if.slave bus
);
  localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int NP = 1 << SW;

  logic [SW-1:0] ptr, g, rr_g, nxt_ptr;
  logic [SW:0]   idx;
  logic [NP-1:0] vpad;
  logic          has_grant, rr_has, man, load_en, gate;
  logic [W-1:0]  data_q;
  logic [SW-1:0] ch_q;
  logic          valid_q;

`ifdef MUX_MANUAL_SEL_EN
  assign man = bus.man_mode;
`else
  assign man = 1'b0;
`endif

  // zero-padded so a manual sel >= N reads as "not valid"
  always_comb begin
    vpad = '0;
    vpad[N-1:0] = bus.in_valid;
  end

  always_comb begin
    rr_has = 1'b0;
    rr_g   = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (!rr_has && vpad[idx[SW-1:0]]) begin
        rr_has = 1'b1;
        rr_g   = idx[SW-1:0];
      end
    end
  end

  always_comb begin
    has_grant = rr_has;
    g         = rr_g;
`ifdef MUX_MANUAL_SEL_EN
    if (man) begin
      has_grant = ({1'b0, bus.sel} < (SW+1)'(N)) && vpad[bus.sel];
      g         = bus.sel;
    end
`endif
  end

  assign load_en = !valid_q || bus.out_ready;
  assign gate    = load_en && has_grant && !rst;
  assign nxt_ptr = (g == SW'(N-1)) ? '0 : g + 1'b1;

  for (genvar c = 0; c < N; c++) begin : g_lane
    mux_rr_n_lane #(.SW(SW), .C(c)) u_lane (
      .gate (gate),
      .g    (g),
      .rdy  (bus.in_ready[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      if (has_grant) begin
        valid_q <= 1'b1;
        data_q  <= bus.in_data[g*W +: W];
        ch_q    <= g;
        if (!man) ptr <= nxt_ptr;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_mux_rr_n.sv
// Randomized plus directed check of mux_rr_n (N=4 and N=3 side by side) against a
// channel-level model: grant = first valid channel scanning from ptr modulo N.
module tb_mux_rr_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_n_if #(.W(8), .N(4)) ifa ();
  mux_rr_n_if #(.W(8), .N(3)) ifb ();

  mux_rr_n #(.W(8), .N(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  mux_rr_n #(.W(8), .N(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int n_checks = 0;
  int n_errors = 0;

  int       m_ptr   [2];
  bit       m_valid [2];
  int       m_data  [2];
  int       m_ch    [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(int n, logic [3:0] v, bit man, int s, int ptr);
    if (man) return (s < n && v[s]) ? s : -1;
    for (int k = 0; k < n; k++)
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  // One clock: drive, check in_ready, step the model, check the output register.
  task automatic cyc(input logic [3:0] v, input logic [31:0] d, input bit rdy,
                     input bit man, input int s, output int ga);
    int gs [2];
    bit les[2];
    bit me;
    me = 1'b0;
    ifa.in_valid = v;      ifa.in_data = d;        ifa.out_ready = rdy;
    ifb.in_valid = v[2:0]; ifb.in_data = d[23:0];  ifb.out_ready = rdy;
`ifdef MUX_MANUAL_SEL_EN
    me = man;
    ifa.man_mode = man; ifa.sel = 2'(s);
    ifb.man_mode = man; ifb.sel = 2'(s);
`endif
    #1;
    for (int i = 0; i < 2; i++) begin
      int n;
      logic [3:0] er, gr;
      n = (i == 0) ? 4 : 3;
      gs[i]  = model_grant(n, (n == 4) ? v : (v & 4'h7), me, s, m_ptr[i]);
      les[i] = !m_valid[i] || rdy;
      er = (gs[i] >= 0 && les[i] && !rst) ? 4'(1 << gs[i]) : 4'h0;
      gr = (i == 0) ? ifa.in_ready : {1'b0, ifb.in_ready};
      chk((i == 0) ? "a.in_ready" : "b.in_ready", gr, er);
    end
    ga = (gs[0] >= 0 && les[0] && !rst) ? gs[0] : -1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int n;
      n = (i == 0) ? 4 : 3;
      if (rst) begin
        m_valid[i] = 0; m_data[i] = 0; m_ch[i] = 0; m_ptr[i] = 0;
      end else if (les[i]) begin
        if (gs[i] >= 0) begin
          m_valid[i] = 1;
          m_data[i]  = int'(d[gs[i]*8 +: 8]);
          m_ch[i]    = gs[i];
          if (!me) m_ptr[i] = (gs[i] + 1) % n;
        end else begin
          m_valid[i] = 0;
        end
      end
    end
    #1;
    chk("a.out_valid", ifa.out_valid, m_valid[0]);
    chk("a.out_data",  ifa.out_data,  m_data[0]);
    chk("a.out_ch",    ifa.out_ch,    m_ch[0]);
    chk("b.out_valid", ifb.out_valid, m_valid[1]);
    chk("b.out_data",  ifb.out_data,  m_data[1]);
    chk("b.out_ch",    ifb.out_ch,    m_ch[1]);
  endtask

  localparam logic [31:0] ALL = 32'hD3C2B1A0;

  initial begin
    int ga;
    logic [3:0]  pv;
    logic [31:0] pd;
    bit          man;
    int          s;
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_valid[i] = 0; m_data[i] = 0; m_ch[i] = 0;
    end

    // reset with producers active: no accepts, cleared register
    rst = 1'b1;
    cyc(4'hF, ALL, 1, 0, 0, ga);
    cyc(4'hF, ALL, 1, 0, 0, ga);
    chk("reset.accept", ga, -1);
    rst = 1'b0;
    cyc(4'h0, ALL, 1, 0, 0, ga);
    cyc(4'h0, ALL, 1, 0, 0, ga);

    // all valid: strict 0,1,2,3,0 rotation at one word per cycle
    for (int i = 0; i < 5; i++) begin
      cyc(4'hF, ALL, 1, 0, 0, ga);
      chk("rr.order", ga, i % 4);
    end
    chk("rr.word", ifa.out_data, 8'hA0);

    // lone channel 2, then channel 1 joins and wins after ptr wraps
    rst = 1'b1; cyc(4'h0, 0, 1, 0, 0, ga); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0100, 32'h005C0000, 1, 0, 0, ga);
      chk("solo.grant", ga, 2);
    end
    cyc(4'b0110, 32'h005C4400, 1, 0, 0, ga);
    chk("join.first", ga, 1);
    cyc(4'b0110, 32'h005C4400, 1, 0, 0, ga);
    chk("join.second", ga, 2);

    // stall with B1 held, then drain and load on the same edge
    rst = 1'b1; cyc(4'h0, 0, 1, 0, 0, ga); rst = 1'b0;
    cyc(4'hF, ALL, 1, 0, 0, ga);
    cyc(4'hF, ALL, 1, 0, 0, ga);
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, ALL, 0, 0, 0, ga);
      chk("stall.hold", ifa.out_data, 8'hB1);
      chk("stall.accept", ga, -1);
    end
    cyc(4'hF, ALL, 1, 0, 0, ga);
    chk("stall.release", ga, 2);

`ifdef MUX_MANUAL_SEL_EN
    for (int i = 0; i < 3; i++) begin
      cyc(4'hF, ALL, 1, 1, 3, ga);
      chk("man.sel3", ga, 3);
    end
    cyc(4'b0111, ALL, 1, 1, 3, ga);
    chk("man.novalid", ga, -1);
    cyc(4'hF, ALL, 1, 0, 0, ga);
    chk("man.resume", ga, 3);
`endif

    // random traffic; producers hold valid until channel accepts on dut_a
    pv = '0;
    pd = '0;
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < 4; c++)
        if (!pv[c]) begin
          pv[c] = 1'($urandom_range(0, 1));
          pd[c*8 +: 8] = 8'($urandom);
        end
      rst = ($urandom_range(0, 63) == 0);
      man = 1'b0;
      s   = $urandom_range(0, 3);
`ifdef MUX_MANUAL_SEL_EN
      man = ($urandom_range(0, 3) == 0);
`endif
      cyc(pv, pd, 1'($urandom_range(0, 3) != 0), man, s, ga);
      if (ga >= 0) pv[ga] = 1'b0;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
